// File: rtl/mant_mul_arbiter_if.sv
// Request/response bundle between the FP units and the shared mantissa
// multiplier arbiter. Requesters and the response consumer use the master
// view; the arbiter uses the slave view.
interface mant_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  // Per-requester operation request; operand i lives at [24*i+23:24*i].
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [24*N_REQ-1:0] req_a;
  logic [24*N_REQ-1:0] req_b;

  // Single shared response channel.
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [47:0]         rsp_product;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product
  );
endinterface

// File: rtl/mant_mul_arbiter.sv
// Round-robin arbiter sharing one combinational 24x24 unsigned mantissa
// multiplier (radix-4 Booth partial products, carry-save Wallace reduction)
// among N_REQ requesters. Operands are registered in front of the multiplier
// (stage 1) and the 48-bit product behind it (stage 2). A single stall signal
// freezes the whole pipeline while the response is not accepted.

// Combinational 24x24 unsigned multiplier.
// The multiplier b is zero-extended to 26 bits so the top Booth digit is never
// negative. Every partial product is kept as a 48-bit two's-complement value;
// since the exact product fits in 48 bits, summing mod 2^48 is exact.
module mant_booth_mul (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] p
);
  localparam int N_PP = 13;

  // b with an implicit zero below bit 0 and two zero bits above bit 23:
  // b_win[k+1] == b[k], so digit j looks at b_win[2j+2:2j].
  logic [26:0] b_win;
  logic [47:0] a_ext;
  logic [47:0] pp [N_PP];

  assign b_win = {2'b00, b, 1'b0};
  assign a_ext = {24'd0, a};

  function automatic logic [47:0] csa_sum(input logic [47:0] x, input logic [47:0] y,
                                          input logic [47:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [47:0] csa_carry(input logic [47:0] x, input logic [47:0] y,
                                            input logic [47:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // Booth recoding: digit in {-2,-1,0,+1,+2}, weighted by 4^j.
  for (genvar gi = 0; gi < N_PP; gi++) begin : g_pp
    logic [2:0]  trip;
    logic        one;
    logic        two;
    logic        neg;
    logic [47:0] mag;
    logic [47:0] sgn;

    assign trip = b_win[2*gi+2 : 2*gi];
    assign one  = trip[1] ^ trip[0];
    assign two  = (trip == 3'b100) || (trip == 3'b011);
    assign neg  = trip[2];
    assign mag  = one ? a_ext : (two ? (a_ext << 1) : 48'd0);
    // A "-0" digit (111) yields ~0+1 == 0, so no special case is needed.
    assign sgn  = neg ? (~mag + 48'd1) : mag;
    assign pp[gi] = sgn << (2 * gi);
  end

  // Wallace reduction 13 -> 9 -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
  logic [47:0] l1 [9];
  logic [47:0] l2 [6];
  logic [47:0] l3 [4];
  logic [47:0] l4 [3];
  logic [47:0] l5 [2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_l1
    assign l1[2*gi]   = csa_sum  (pp[3*gi], pp[3*gi+1], pp[3*gi+2]);
    assign l1[2*gi+1] = csa_carry(pp[3*gi], pp[3*gi+1], pp[3*gi+2]);
  end
  assign l1[8] = pp[12];

  for (genvar gi = 0; gi < 3; gi++) begin : g_l2
    assign l2[2*gi]   = csa_sum  (l1[3*gi], l1[3*gi+1], l1[3*gi+2]);
    assign l2[2*gi+1] = csa_carry(l1[3*gi], l1[3*gi+1], l1[3*gi+2]);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_l3
    assign l3[2*gi]   = csa_sum  (l2[3*gi], l2[3*gi+1], l2[3*gi+2]);
    assign l3[2*gi+1] = csa_carry(l2[3*gi], l2[3*gi+1], l2[3*gi+2]);
  end

  assign l4[0] = csa_sum  (l3[0], l3[1], l3[2]);
  assign l4[1] = csa_carry(l3[0], l3[1], l3[2]);
  assign l4[2] = l3[3];

  assign l5[0] = csa_sum  (l4[0], l4[1], l4[2]);
  assign l5[1] = csa_carry(l4[0], l4[1], l4[2]);

  assign p = l5[0] + l5[1];
endmodule

module mant_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  mant_mul_arbiter_if.slave  bus,
  output logic               busy,
  output logic [CNT_W-1:0]   issue_cnt
);
  // Pipeline state.
  logic             s1_valid_reg;
  logic [23:0]      s1_a_reg;
  logic [23:0]      s1_b_reg;
  logic [ID_W-1:0]  s1_id_reg;
  logic             s2_valid_reg;
  logic [47:0]      s2_product_reg;
  logic [ID_W-1:0]  s2_id_reg;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [CNT_W-1:0] issue_cnt_reg;

  // Arbitration signals.
  logic             en;
  logic [ID_W:0]    cand_sum   [N_REQ];
  logic [ID_W-1:0]  cand_idx   [N_REQ];
  logic [N_REQ-1:0] cand_valid;
  logic [ID_W-1:0]  grant;
  logic             found;
  logic             accept;
  logic [23:0]      grant_a;
  logic [23:0]      grant_b;
  logic [47:0]      mul_product;

  // The only back-pressure source is an unaccepted response in stage 2.
  assign en = !(s2_valid_reg && !bus.rsp_ready);

  // Candidate k is the requester k+1 places after the last winner, wrapping
  // at N_REQ (which need not be a power of two).
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand_sum[gi]   = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi + 1);
    assign cand_idx[gi]   = (cand_sum[gi] >= (ID_W+1)'(N_REQ))
                          ? ID_W'(cand_sum[gi] - (ID_W+1)'(N_REQ))
                          : cand_sum[gi][ID_W-1:0];
    assign cand_valid[gi] = bus.req_valid[cand_idx[gi]];
  end

  // Pick the first requesting candidate in round-robin order.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && cand_valid[k]) begin
        grant = cand_idx[k];
        found = 1'b1;
      end
    end
  end

  // Only the winner sees ready, and only while the pipeline can advance.
  always_comb begin
    bus.req_ready = '0;
    if (found && en && !rst) begin
      bus.req_ready[grant] = 1'b1;
    end
  end

  assign accept  = found && en && !rst;
  assign grant_a = bus.req_a[24*grant +: 24];
  assign grant_b = bus.req_b[24*grant +: 24];

  mant_booth_mul u_mul (
    .a (s1_a_reg),
    .b (s1_b_reg),
    .p (mul_product)
  );

  // Stage 1 operand register, round-robin pointer and issue counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_id_reg     <= '0;
      rr_ptr_reg    <= ID_W'(N_REQ - 1);
      issue_cnt_reg <= '0;
    end else if (en) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_a_reg      <= grant_a;
        s1_b_reg      <= grant_b;
        s1_id_reg     <= grant;
        rr_ptr_reg    <= grant;
        issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Stage 2 product register; it holds while the response is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg   <= 1'b0;
      s2_product_reg <= '0;
      s2_id_reg      <= '0;
    end else if (en) begin
      s2_valid_reg   <= s1_valid_reg;
      s2_product_reg <= mul_product;
      s2_id_reg      <= s1_id_reg;
    end
  end

  assign bus.rsp_valid   = s2_valid_reg;
  assign bus.rsp_product = s2_product_reg;
  assign bus.rsp_id      = s2_id_reg;
  assign busy            = s1_valid_reg | s2_valid_reg;
  assign issue_cnt       = issue_cnt_reg;
endmodule

// File: tb/tb_mant_mul_arbiter.sv
// Self-checking bench for mant_mul_arbiter: a behavioural model (round-robin
// rule, two-slot pipeline, in-order scoreboard of a*b) compared every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_mant_mul_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] issue_cnt;

  mant_mul_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  mant_mul_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_rsp   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    longint unsigned x;
    x = 64'(a) * 64'(b);
    return x[47:0];
  endfunction

  // Behavioural model state.
  typedef struct { int id; logic [47:0] p; } rsp_t;
  rsp_t             sb[$];
  bit               m_v1 = 1'b0;
  bit               m_v2 = 1'b0;
  int               m_id1 = 0;
  int               m_id2 = 0;
  logic [47:0]      m_p1 = '0;
  logic [47:0]      m_p2 = '0;
  int               m_last = N_REQ - 1;
  logic [CNT_W-1:0] m_cnt = '0;

  // Compare DUT against the model just before each rising edge, then advance
  // the model by what that edge will do.
  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_ready;
    int               g;
    int               idx;
    bit               m_en;
    logic [23:0]      ga;
    logic [23:0]      gb;
    rsp_t             e;

    m_en = !(m_v2 && !bus.rsp_ready);
    g = -1;
    if (!rst && m_en) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (m_last + 1 + k) % N_REQ;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;

    check("req_ready", bus.req_ready, exp_ready);
    check("rsp_valid", bus.rsp_valid, m_v2);
    if (m_v2) begin
      check("rsp_id", bus.rsp_id, m_id2);
      check("rsp_product", bus.rsp_product, m_p2);
    end
    check("busy", busy, m_v1 | m_v2);
    check("issue_cnt", issue_cnt, m_cnt);

    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_order: got a response with id %0d, required none pending", bus.rsp_id);
      end else begin
        e = sb.pop_front();
        check("sb_id", bus.rsp_id, e.id);
        check("sb_product", bus.rsp_product, e.p);
      end
    end

    if (rst) begin
      m_v1 = 1'b0; m_v2 = 1'b0; m_id2 = 0; m_p2 = '0;
      m_last = N_REQ - 1; m_cnt = '0;
      sb.delete();
    end else if (m_en) begin
      m_v2 = m_v1; m_id2 = m_id1; m_p2 = m_p1;
      m_v1 = (g >= 0);
      if (g >= 0) begin
        ga = bus.req_a[24*g +: 24];
        gb = bus.req_b[24*g +: 24];
        m_id1 = g;
        m_p1 = ref_mul(ga, gb);
        m_last = g;
        m_cnt = m_cnt + 1;
        sb.push_back('{g, m_p1});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [23:0] a, input logic [23:0] b);
    bus.req_a[24*i +: 24] = a;
    bus.req_b[24*i +: 24] = b;
  endtask

  logic [23:0] t4_a0;
  logic [23:0] t4_b0;
  int          rsp_mark;
  int          ops;
  int          cyc;
  bit          acc;

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_product", bus.rsp_product, 0);
    check("rst_busy", busy, 0);
    check("rst_issue_cnt", issue_cnt, 0);

    // 1: single op, latency and counter.
    set_req(0, 24'd3, 24'd5);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    check("t1_rsp_valid_k", bus.rsp_valid, 0);
    step();
    check("t1_rsp_valid", bus.rsp_valid, 1);
    check("t1_product", bus.rsp_product, 48'd15);
    check("t1_id", bus.rsp_id, 0);
    check("t1_issue_cnt", issue_cnt, 1);
    step();

    // 2: operand extremes on requester 2.
    set_req(2, 24'hFFFFFF, 24'hFFFFFF);
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    step();
    check("t2_max_product", bus.rsp_product, 48'hFFFFFE000001);
    check("t2_max_id", bus.rsp_id, 2);
    set_req(2, 24'h800000, 24'h000002);
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    step();
    check("t2_msb_product", bus.rsp_product, 48'h000001000000);
    check("t2_msb_id", bus.rsp_id, 2);
    step();

    // 3: all four requesting, strict rotation from requester 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_req(i, 24'h00A000 + 24'(i), 24'h000B00 * 24'(i + 1));
    rsp_mark = n_rsp;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t3_grant", bus.req_ready, 64'(4'b0001 << (c % 4)));
      step();
    end
    bus.req_valid = '0;
    check("t3_issue_cnt", issue_cnt, 8);
    step();
    step();
    check("t3_rsp_count", 64'(n_rsp - rsp_mark), 8);

    // 4: response stall with a full pipeline.
    t4_a0 = 24'h00A000;
    t4_b0 = 24'h000B00;
    bus.req_valid = 4'b1111;
    step();
    step();
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_stall_ready", bus.req_ready, 0);
      check("t4_stall_valid", bus.rsp_valid, 1);
      check("t4_stall_id", bus.rsp_id, 0);
      check("t4_stall_product", bus.rsp_product, ref_mul(t4_a0, t4_b0));
      check("t4_stall_cnt", issue_cnt, 10);
      step();
    end
    bus.rsp_ready = 1'b1;
    repeat (4) step();
    bus.req_valid = '0;
    repeat (3) step();
    check("t4_drained_busy", busy, 0);
    check("t4_sb_empty", 64'(sb.size()), 0);

    // 5: reset with both stages valid.
    bus.req_valid = 4'b1111;
    step();
    step();
    check("t5_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rsp_valid", bus.rsp_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_issue_cnt", issue_cnt, 0);
    @(negedge clk);
    check("t5_first_grant", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    repeat (3) step();

    // 6: requester 1 alone, random operands and response back-pressure.
    rsp_mark = n_rsp;
    set_req(1, 24'($urandom), 24'($urandom));
    bus.req_valid = 4'b0010;
    ops = 0;
    cyc = 0;
    while (ops < 100 && cyc < 3000) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.req_ready[1];
      step();
      cyc++;
      if (acc) begin
        ops++;
        set_req(1, 24'($urandom), 24'($urandom));
      end
    end
    check("t6_ops_accepted", 64'(ops), 100);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) step();
    check("t6_rsp_count", 64'(n_rsp - rsp_mark), 100);
    check("t6_sb_empty", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
